// File: rtl/am2940_dma_seq.sv
// am2940_dma_seq
// Sequencing controller for an Am2940-style DMA address generator. It decodes
// the 3-bit instruction field from the microprogram pipeline register and owns
// the control register, the address and word-count registers and their
// counters. While a transfer runs, every accepted step advances the counters,
// and the controller flags completion according to the selected mode.
//
// Parameters:
//   WIDTH      width of the address and word-count datapath (>= 4)
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   instr      instruction: 0 WRCR, 1 RDCR, 2 RDWC, 3 RDAC,
//              4 REINIT, 5 LDADDR, 6 LDWC, 7 ENCNT
//   instr_vld  instr is valid this cycle
//   step       one DMA transfer completed
//   data_in    load data for WRCR / LDADDR / LDWC
//   data_out   read-back data (zero when data_oe is low)
//   data_oe    data_out valid, one cycle after a read instruction
//   addr_out   current address counter
//   busy       transfer running
//   done       transfer terminated (sticky until a load or REINIT)
//
// Optional feature, enabled by defining AM2940_DONE_IRQ_EN:
//   irq_mask   input, suppresses the completion interrupt when high
//   irq        output, one-cycle pulse on the cycle done rises
module am2940_dma_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       instr,
    input  logic             instr_vld,
    input  logic             step,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_oe,
    output logic [WIDTH-1:0] addr_out,
    output logic             busy,
    output logic             done
`ifdef AM2940_DONE_IRQ_EN
    ,
    input  logic             irq_mask,
    output logic             irq
`endif
);

    localparam logic [2:0] OP_WRCR   = 3'd0;
    localparam logic [2:0] OP_RDCR   = 3'd1;
    localparam logic [2:0] OP_RDWC   = 3'd2;
    localparam logic [2:0] OP_RDAC   = 3'd3;
    localparam logic [2:0] OP_REINIT = 3'd4;
    localparam logic [2:0] OP_LDADDR = 3'd5;
    localparam logic [2:0] OP_LDWC   = 3'd6;
    localparam logic [2:0] OP_ENCNT  = 3'd7;

    localparam logic [1:0] MODE_WC_DOWN = 2'd0;
    localparam logic [1:0] MODE_WC_UP   = 2'd1;
    localparam logic [1:0] MODE_ADDR    = 2'd2;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [2:0]       cr;
    logic [WIDTH-1:0] addr_reg;
    logic [WIDTH-1:0] addr_cnt;
    logic [WIDTH-1:0] wc_reg;
    logic [WIDTH-1:0] wc_cnt;

    logic [1:0]       mode;
    logic             is_read;
    logic             step_en;
    logic             term;
    logic [WIDTH-1:0] addr_nxt;
    logic [WIDTH-1:0] wc_nxt;
    logic [WIDTH-1:0] wc_inc;

    assign mode = cr[1:0];

    // Decide whether a step is accepted this cycle, what the counters would
    // become, whether that step ends the transfer, and the next FSM state.
    // Any instruction other than a read takes priority over a step.
    always_comb begin
        state_next = state;
        is_read    = instr_vld && (instr == OP_RDCR || instr == OP_RDWC ||
                                   instr == OP_RDAC);
        step_en    = step && (state == S_RUN) && (!instr_vld || is_read);
        addr_nxt   = cr[2] ? (addr_cnt - ONE) : (addr_cnt + ONE);
        wc_inc     = wc_cnt + ONE;
        wc_nxt     = wc_cnt;
        term       = 1'b0;

        case (mode)
            MODE_WC_DOWN: begin
                wc_nxt = wc_cnt - ONE;
                term   = (wc_cnt == ONE);
            end
            MODE_WC_UP: begin
                wc_nxt = wc_inc;
                term   = (wc_inc == wc_reg);
            end
            MODE_ADDR: begin
                term   = (addr_nxt == wc_reg);
            end
            default: begin
                wc_nxt = wc_inc;
            end
        endcase

        if (instr_vld) begin
            case (instr)
                OP_WRCR, OP_LDADDR, OP_LDWC: state_next = S_IDLE;
                OP_REINIT:                   state_next = S_ARMED;
                OP_ENCNT: begin
                    if (state == S_ARMED) begin
                        state_next = S_RUN;
                    end
                end
                default: ;
            endcase
        end

        if (step_en && term) begin
            state_next = S_DONE;
        end
    end

    // State register plus the control/address/count registers. Loads and
    // REINIT never coincide with an accepted step because step_en excludes
    // every non-read instruction, so the counter writes cannot collide.
    // Mode 1 counts up from zero, so its word counter is cleared on load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cr       <= '0;
            addr_reg <= '0;
            addr_cnt <= '0;
            wc_reg   <= '0;
            wc_cnt   <= '0;
            data_out <= '0;
            data_oe  <= 1'b0;
        end else begin
            state    <= state_next;
            data_oe  <= is_read;
            data_out <= '0;

            if (instr_vld) begin
                case (instr)
                    OP_WRCR:   cr <= data_in[2:0];
                    OP_RDCR:   data_out <= WIDTH'(cr);
                    OP_RDWC:   data_out <= wc_cnt;
                    OP_RDAC:   data_out <= addr_cnt;
                    OP_REINIT: begin
                        addr_cnt <= addr_reg;
                        wc_cnt   <= (mode == MODE_WC_UP) ? '0 : wc_reg;
                    end
                    OP_LDADDR: begin
                        addr_reg <= data_in;
                        addr_cnt <= data_in;
                    end
                    OP_LDWC: begin
                        wc_reg <= data_in;
                        wc_cnt <= (mode == MODE_WC_UP) ? '0 : data_in;
                    end
                    default: ;
                endcase
            end

            if (step_en) begin
                addr_cnt <= addr_nxt;
                wc_cnt   <= wc_nxt;
            end
        end
    end

`ifdef AM2940_DONE_IRQ_EN
    // Done can only rise from a terminating step in RUN, so registering that
    // event gives a pulse aligned with the first cycle done reads high.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= step_en && term && !irq_mask;
        end
    end
`endif

    assign addr_out = addr_cnt;
    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);

endmodule
